// File: rtl/lc3b_types.sv
// Shared LC-3b perf counter types: register decode, CTRL bit positions and counter width type.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [31:0] lc3b_perfcnt_t;

    localparam int unsigned PERFCNT_CTRL_COUNT_EN = 0;
    localparam int unsigned PERFCNT_CTRL_IRQ_EN   = 1;
    localparam int unsigned PERFCNT_CTRL_BITS     = 2;
    localparam logic [PERFCNT_CTRL_BITS-1:0] PERFCNT_CTRL_RESET = 2'b01;

    typedef enum logic [2:0] {
        RegCntLo,
        RegCntHi,
        RegCtrl,
        RegOvf,
        RegNone
    } perfcnt_reg_e;

    // Counters occupy 0..2*num_ch-1 as lo/hi pairs, then CTRL and OVF.
    function automatic perfcnt_reg_e perfcnt_decode(input int unsigned sel,
                                                    input int unsigned num_ch);
        if (sel < 2 * num_ch) begin
            return sel[0] ? RegCntHi : RegCntLo;
        end
        if (sel == 2 * num_ch) begin
            return RegCtrl;
        end
        if (sel == 2 * num_ch + 1) begin
            return RegOvf;
        end
        return RegNone;
    endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One performance counter: level/edge qualification, saturate or wrap at all-ones, clear.
module perf_counter_channel #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          EDGE      = 1'b0,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_event,
    input  logic                 i_count_en,
    input  logic                 i_clear,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_ovf
);

    logic                 r_prev;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_d;
    logic                 w_qual;
    logic                 w_inc;
    logic                 w_at_max;

    always_comb begin
        w_qual    = EDGE ? (i_event & ~r_prev) : i_event;
        // A clear in the same cycle suppresses the increment and its overflow.
        w_inc     = i_count_en & w_qual & ~i_clear;
        w_at_max  = &r_count;
        o_ovf     = w_inc & w_at_max;
        w_count_d = r_count;
        if (i_clear) begin
            w_count_d = '0;
        end else if (w_inc) begin
            if (!w_at_max) begin
                w_count_d = r_count + CNT_WIDTH'(1);
            end else if (!SATURATE) begin
                w_count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_prev  <= i_event;
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/perf_counter_bank.sv
// MMIO bank of event counters with 16-bit halves and shared high-half snapshot.
// Optional sticky overflow flags and interrupt are built when PERFCNT_OVF_IRQ_EN is defined.
module perf_counter_bank
    import lc3b_types::*;
#(
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned CNT_WIDTH = 32,
    parameter logic [15:0] EDGE_MASK = 16'h0000,
    parameter bit          SATURATE  = 1'b1,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [ADDR_W-1:0] mmio_sel,
    input  logic              mmio_read,
    input  logic              mmio_write,
    input  lc3b_word          mmio_wdata,
    output lc3b_word          mmio_rdata,
    output logic              mmio_resp,
    output logic              ovf_irq
);

    logic [CNT_WIDTH-1:0]         w_cnt [NUM_CH];
    lc3b_perfcnt_t                w_cnt_ext [NUM_CH];
    logic [NUM_CH-1:0]            w_clear;
    logic [NUM_CH-1:0]            w_ovf_pulse;
    logic [NUM_CH-1:0]            w_ovf_rd;
    logic [PERFCNT_CTRL_BITS-1:0] r_ctrl;
    lc3b_word                     r_snap;
    lc3b_word                     w_snap_d;
    lc3b_word                     r_rdata;
    lc3b_word                     w_rdata;
    logic                         r_resp;
    int unsigned                  w_sel;
    perfcnt_reg_e                 w_kind;
    logic                         w_is_cnt;
    logic                         w_rd_only;
    logic                         w_ctrl_wr;

    assign w_sel     = 32'(mmio_sel);
    assign w_kind    = perfcnt_decode(w_sel, NUM_CH);
    assign w_is_cnt  = (w_kind == RegCntLo) || (w_kind == RegCntHi);
    assign w_rd_only = mmio_read & ~mmio_write;
    assign w_ctrl_wr = mmio_write & (w_kind == RegCtrl);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_clear[c]   = mmio_write & w_is_cnt & ((w_sel >> 1) == 32'(c));
        assign w_cnt_ext[c] = lc3b_perfcnt_t'(w_cnt[c]);

        perf_counter_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .EDGE      (EDGE_MASK[c]),
            .SATURATE  (SATURATE)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .i_event    (event_in[c]),
            .i_count_en (r_ctrl[PERFCNT_CTRL_COUNT_EN]),
            .i_clear    (w_clear[c]),
            .o_count    (w_cnt[c]),
            .o_ovf      (w_ovf_pulse[c])
        );
    end

    // A read that collides with a write returns 0 and does not touch the snapshot.
    always_comb begin
        w_rdata  = '0;
        w_snap_d = r_snap;
        if (w_rd_only) begin
            case (w_kind)
                RegCntLo: begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        if ((w_sel >> 1) == c) begin
                            w_rdata  = w_cnt_ext[c][15:0];
                            w_snap_d = w_cnt_ext[c][31:16];
                        end
                    end
                end
                RegCntHi: w_rdata = r_snap;
                RegCtrl:  w_rdata = 16'(r_ctrl);
                RegOvf:   w_rdata = 16'(w_ovf_rd);
                default:  w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl  <= PERFCNT_CTRL_RESET;
            r_snap  <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= mmio_wdata[PERFCNT_CTRL_BITS-1:0];
            end
            r_snap  <= w_snap_d;
            r_rdata <= w_rdata;
            r_resp  <= mmio_read | mmio_write;
        end
    end

`ifdef PERFCNT_OVF_IRQ_EN
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] w_ovf_d;
    logic [NUM_CH-1:0] w_ovf_clr;
    logic              w_ovf_wr;
    logic              r_irq;

    assign w_ovf_wr  = mmio_write & (w_kind == RegOvf);
    assign w_ovf_clr = w_ovf_wr ? mmio_wdata[NUM_CH-1:0] : '0;
    // New overflow wins over a same-cycle write-1-to-clear.
    assign w_ovf_d   = (r_ovf & ~w_ovf_clr) | w_ovf_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ovf <= w_ovf_d;
            r_irq <= (|r_ovf) & r_ctrl[PERFCNT_CTRL_IRQ_EN];
        end
    end

    assign w_ovf_rd = r_ovf;
    assign ovf_irq  = r_irq;
`else
    assign w_ovf_rd = '0;
    assign ovf_irq  = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{mmio_wdata, w_ovf_pulse};

    assign mmio_rdata = r_rdata;
    assign mmio_resp  = r_resp;

endmodule
